// File: rtl/eq_regmap_pkg.sv
// Shared constants and address helper for the equalizer configuration register map.
package eq_regmap_pkg;

    localparam int ADDR_CONFIG    = 0;
    localparam int ADDR_GAIN_BASE = 1;
    localparam int BYTES_PER_GAIN = 3;
    localparam int NUM_BANDS      = 10;
    localparam int NUM_REGS       = 31;
    localparam int LAST_ADDR      = 30;

    // Byte address of lane b (0 = LSB) of band n (1..10).
    function automatic int band_byte_addr(input int n, input int b);
        return ADDR_GAIN_BASE + BYTES_PER_GAIN * (n - 1) + b;
    endfunction

endpackage

// File: rtl/reg_map.sv
// Write-only byte register bank presenting the equalizer configuration word
// and ten little-endian 24-bit band gains straight from the registers.
module reg_map
    import eq_regmap_pkg::*;
#(
    parameter int GAIN_WIDTH = 24,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            data_in,
    output logic [7:0]            configuration,
    output logic [GAIN_WIDTH-1:0] gain_1,
    output logic [GAIN_WIDTH-1:0] gain_2,
    output logic [GAIN_WIDTH-1:0] gain_3,
    output logic [GAIN_WIDTH-1:0] gain_4,
    output logic [GAIN_WIDTH-1:0] gain_5,
    output logic [GAIN_WIDTH-1:0] gain_6,
    output logic [GAIN_WIDTH-1:0] gain_7,
    output logic [GAIN_WIDTH-1:0] gain_8,
    output logic [GAIN_WIDTH-1:0] gain_9,
    output logic [GAIN_WIDTH-1:0] gain_10
);

    logic [7:0]            regs_q [NUM_REGS];
    logic [7:0]            regs_d [NUM_REGS];
    logic [GAIN_WIDTH-1:0] gains  [NUM_BANDS];

    // Next-state: full-width address compare per register, so addresses past
    // the last register match nothing and can never alias onto a low register.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (we && (addr == ADDR_WIDTH'(i))) begin
                regs_d[i] = data_in;
            end
        end
    end

    // Register storage: asynchronous active-low clear of every byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Each gain is three consecutive bytes, lowest address in the LSB lane.
    for (genvar n = 1; n <= NUM_BANDS; n++) begin : g_band
        assign gains[n-1] = {regs_q[band_byte_addr(n, 2)],
                             regs_q[band_byte_addr(n, 1)],
                             regs_q[band_byte_addr(n, 0)]};
    end

    assign configuration = regs_q[ADDR_CONFIG];
    assign gain_1        = gains[0];
    assign gain_2        = gains[1];
    assign gain_3        = gains[2];
    assign gain_4        = gains[3];
    assign gain_5        = gains[4];
    assign gain_6        = gains[5];
    assign gain_7        = gains[6];
    assign gain_8        = gains[7];
    assign gain_9        = gains[8];
    assign gain_10       = gains[9];

endmodule

// File: tb/tb_reg_map.sv
// Directed self-checking bench for the equalizer register map.
module tb_reg_map;

    logic        clk;
    logic        rst;
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  data_in;
    logic [7:0]  configuration;
    logic [23:0] gainObs [10];

    logic [7:0]  expConfig;
    logic [23:0] expGain [10];
    logic [7:0]  byteTab [31];

    int checks   = 0;
    int failures = 0;

    reg_map #(.GAIN_WIDTH(24), .ADDR_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .we            (we),
        .addr          (addr),
        .data_in       (data_in),
        .configuration (configuration),
        .gain_1        (gainObs[0]),
        .gain_2        (gainObs[1]),
        .gain_3        (gainObs[2]),
        .gain_4        (gainObs[3]),
        .gain_5        (gainObs[4]),
        .gain_6        (gainObs[5]),
        .gain_7        (gainObs[6]),
        .gain_8        (gainObs[7]),
        .gain_9        (gainObs[8]),
        .gain_10       (gainObs[9])
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison with an immediate assertion.
    task automatic checkOutput(input string tag, input logic [23:0] observed, input logic [23:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Compare every output against the bench's expected state.
    task automatic checkAll(input string step);
        checkOutput($sformatf("%s config", step), {16'h0, configuration}, {16'h0, expConfig});
        for (int n = 0; n < 10; n++) begin
            checkOutput($sformatf("%s gain_%0d", step, n + 1), gainObs[n], expGain[n]);
        end
    endtask

    // Single write: drive on falling edge, capture on next rising edge, release 1 after.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        we      = 1'b1;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        we      = 1'b1;
        addr    = 8'd5;
        data_in = 8'hFF;
        expConfig = 8'h00;
        for (int n = 0; n < 10; n++) expGain[n] = 24'h0;

        // Reset held low while clocking a write: nothing may change.
        #1;
        checkAll("reset_t0");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkAll($sformatf("reset_c%0d", c));
        end

        @(negedge clk);
        we  = 1'b0;
        rst = 1'b1;

        // Full programming: configuration plus ten bands, LSB byte first.
        byteTab = '{8'hAA,
                    8'h00, 8'h00, 8'h00,
                    8'hC7, 8'h71, 8'h1C,
                    8'h8E, 8'hE3, 8'h38,
                    8'h55, 8'h3F, 8'h55,
                    8'h1E, 8'hAB, 8'h71,
                    8'hE6, 8'h16, 8'h8E,
                    8'hAF, 8'h82, 8'hAA,
                    8'h78, 8'hEE, 8'hC6,
                    8'h41, 8'h5A, 8'hE3,
                    8'hFF, 8'hFF, 8'hFF};
        for (int i = 0; i < 31; i++) begin
            applyStimulus(8'(i), byteTab[i]);
        end
        expConfig  = 8'hAA;
        expGain[0] = 24'h000000;
        expGain[1] = 24'h1C71C7;
        expGain[2] = 24'h38E38E;
        expGain[3] = 24'h553F55;
        expGain[4] = 24'h71AB1E;
        expGain[5] = 24'h8E16E6;
        expGain[6] = 24'hAA82AF;
        expGain[7] = 24'hC6EE78;
        expGain[8] = 24'hE35A41;
        expGain[9] = 24'hFFFFFF;
        checkAll("program");

        // Byte-lane isolation: middle byte of band 2 only.
        applyStimulus(8'd5, 8'h00);
        expGain[1] = 24'h1C00C7;
        checkAll("lane");

        // Out-of-range addresses, including ones whose low bits alias real registers.
        applyStimulus(8'd31, 8'h12);
        applyStimulus(8'd255, 8'h34);
        applyStimulus(8'd32, 8'h56);
        applyStimulus(8'd33, 8'h78);
        checkAll("oob");

        // Write enable low: presented data must be ignored.
        @(negedge clk);
        we      = 1'b0;
        addr    = 8'd0;
        data_in = 8'h55;
        @(posedge clk);
        #1;
        checkAll("we_low");

        // Zero latency: visible 1 time unit after the capturing edge.
        applyStimulus(8'd28, 8'h01);
        expGain[9] = 24'hFFFF01;
        checkAll("latency");

        // Back-to-back rewrites of one address: last write wins.
        applyStimulus(8'd30, 8'h10);
        applyStimulus(8'd30, 8'h20);
        expGain[9] = 24'h20FF01;
        checkAll("last_wins");

        // Asynchronous reset between edges clears outputs before the next edge.
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        expConfig = 8'h00;
        for (int n = 0; n < 10; n++) expGain[n] = 24'h0;
        checkAll("async_rst");
        #1;
        rst = 1'b1;

        // Writes work normally after reset release.
        applyStimulus(8'd0, 8'h3C);
        applyStimulus(8'd16, 8'h9A);
        expConfig  = 8'h3C;
        expGain[5] = 24'h00009A;
        checkAll("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_map.md
Name: reg_map

Overview:
- Byte-addressed, write-only configuration register bank for the 10-band digital audio equalizer.
- A host/serial-interface bridge writes one byte per cycle.
- The block continuously presents one 8-bit configuration word and ten 24-bit band gains to the filter/gain datapath.
- Gains are assembled little-endian from three consecutive byte registers.

Parameters:
- GAIN_WIDTH, 24, width of each band gain output; only 24 (3 bytes) is supported.
- ADDR_WIDTH, 8, width of the byte address bus.

Ports:
- clk  input  1  system clock; all register updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- we  input  1  write enable; sampled on rising clk edge.
- addr  input  ADDR_WIDTH  byte address of the write.
- data_in  input  8  write data byte.
- configuration  output  8  contents of register 0.
- gain_1 … gain_10  output  GAIN_WIDTH each  band gains 1..10, unsigned.

Behaviour:
- Storage: 31 byte registers, reg[0..30].
  - reg[0] = configuration.
  - reg[1..30] = gain bytes.
- Reset: rst low asynchronously clears all 31 registers to 0x00, so configuration = 0x00 and every gain_n = 0. Registers hold 0 while rst is low; writes are ignored during reset.
- Write: on a rising clk edge with rst high and we = 1:
  - if addr ≤ 30, reg[addr] <= data_in;
  - otherwise the write is ignored, with no aliasing and no wrap.
- we = 0: all registers hold.
- One write per cycle; back-to-back writes on consecutive cycles are all captured.
- Gain mapping for band n = 1..10: gain_n = {reg[3n], reg[3n-1], reg[3n-2]}.
  - Lowest address is the LSB; e.g. gain_1 = {reg[3], reg[2], reg[1]} and gain_10 = {reg[30], reg[29], reg[28]}.
- Outputs are pure continuous assignments from the registers (no output pipeline).
  - A write captured at edge k is visible on the outputs immediately after edge k (zero extra latency).
- Partial update: writing one byte of a gain changes only that byte lane; other bytes keep prior values. No shadow/commit mechanism exists, so intermediate values are visible between byte writes.
- Rewriting an address overwrites it; the last write wins.
- Reset asserted mid-sequence clears everything immediately, regardless of clk.
- No read-back port.

Decomposition:
- Shared package `eq_regmap_pkg`:
  - ADDR_CONFIG = 0
  - ADDR_GAIN_BASE = 1
  - BYTES_PER_GAIN = 3
  - NUM_BANDS = 10
  - NUM_REGS = 31
  - LAST_ADDR = 30
  - a function band_byte_addr(n, b) = ADDR_GAIN_BASE + 3*(n-1) + b.
- Single flat module; no sub-module needed. The register array plus generate-based gain concatenation is sufficient.

Test Plan:
- Reset check: hold rst low, toggle clk with we = 1, addr = 5, data_in = 0xFF -> configuration = 0x00 and all gains = 0 throughout.
- Full programming: release rst, then write:
  - addr 0 = 0xAA; gain bytes per band (LSB first):
  - band 1: 00 00 00
  - band 2: C7 71 1C
  - band 3: 8E E3 38
  - band 4: 55 3F 55
  - band 5: 1E AB 71
  - band 6: E6 16 8E
  - band 7: AF 82 AA
  - band 8: 78 EE C6
  - band 9: 41 5A E3
  - band 10: FF FF FF
  - Required: configuration = 0xAA, gain_1 = 0, gain_2 = 0x1C71C7 (1864135), gain_3 = 0x38E38E (3728270), gain_4 = 0x553F55 (5586773), gain_5 = 0x71AB1E, gain_6 = 0x8E16E6, gain_7 = 0xAA82AF, gain_8 = 0xC6EE78, gain_9 = 0xE35A41, gain_10 = 0xFFFFFF (16777215).
- Byte-lane isolation: after full programming, write addr 5 = 0x00 -> gain_2 = 0x1C00C7; all other outputs unchanged.
- Out-of-range / we low:
  - write addr 31 = 0x12 and addr 255 = 0x34 -> no output changes;
  - present addr 0, data 0x55 with we = 0 -> configuration stays 0xAA.
- Latency: single write of addr 28 = 0x01 -> gain_10[7:0] = 0x01 immediately after the capturing edge, not one cycle later.
- Async reset mid-operation: after programming, pulse rst low between clock edges -> all outputs 0 at once, before the next clk edge; subsequent writes work normally.
